// File: rtl/mem_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states and
// the alignment rule used when an access is accepted.
package mem_pkg;

  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  // Bytes are always aligned; halves need addr[0] = 0; word and the
  // reserved encoding need addr[1:0] = 00.
  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [1:0] addr_lo);
    logic mis;
    case (size)
      SZ_BYTE: mis = 1'b0;
      SZ_HALF: mis = addr_lo[0];
      default: mis = (addr_lo != 2'b00);
    endcase
    is_misaligned = mis;
  endfunction

endpackage

// File: rtl/mem_access_unit_lane_align.sv
// Combinational lane steering: store byte enables and lane replication,
// and load lane selection with zero/sign extension.
// No state; latency is zero.
module lane_align
  import mem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic        sign_ext,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_lane,
  output logic [31:0] rdata_ext
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  // Store side: place the byte/half in every lane and enable the addressed one(s).
  always_comb begin
    be         = 4'b1111;
    wdata_lane = wdata;
    case (size)
      SZ_BYTE: begin
        be         = 4'b0001 << addr_lo;
        wdata_lane = {4{wdata[7:0]}};
      end
      SZ_HALF: begin
        be         = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_lane = {2{wdata[15:0]}};
      end
      default: begin
        be         = 4'b1111;
        wdata_lane = wdata;
      end
    endcase
  end

  // Load side: pick the addressed lane, then fill upper bits with zero or the lane MSB.
  always_comb begin
    sel_byte  = rdata[7:0];
    sel_half  = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    rdata_ext = rdata;
    case (addr_lo)
      2'd0: sel_byte = rdata[7:0];
      2'd1: sel_byte = rdata[15:8];
      2'd2: sel_byte = rdata[23:16];
      default: sel_byte = rdata[31:24];
    endcase
    case (size)
      SZ_BYTE: rdata_ext = {{24{sign_ext & sel_byte[7]}}, sel_byte};
      SZ_HALF: rdata_ext = {{16{sign_ext & sel_half[15]}}, sel_half};
      default: rdata_ext = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Multi-cycle load/store unit between the MEM stage and the system bridge.
// Aligned access: accept N, bus_req N+1, rsp_valid N+2 with immediate ack; misaligned: rsp_valid N+1.
// One access in flight; req_ready only in IDLE; a missing ack ends in a bus error after TIMEOUT cycles.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_adel,
  output logic        rsp_ades,
  output logic        rsp_buserr
);

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      state, next_state;
  logic [7:0]  cnt;

  logic        we_q;
  logic [1:0]  size_q;
  logic        signed_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;

  logic [31:0] rdata_q;
  logic        adel_q;
  logic        ades_q;
  logic        buserr_q;

  logic        misal;
  logic        accept;
  logic        done_ack;
  logic        done_to;

  logic [3:0]  lane_be;
  logic [31:0] lane_wdata;
  logic [31:0] lane_rdata;

  assign misal = is_misaligned(req_size, req_addr[1:0]);

  lane_align u_lane_align (
    .size       (size_q),
    .addr_lo    (addr_q[1:0]),
    .sign_ext   (signed_q),
    .wdata      (wdata_q),
    .rdata      (bus_rdata),
    .be         (lane_be),
    .wdata_lane (lane_wdata),
    .rdata_ext  (lane_rdata)
  );

  // State register; async reset aborts any access, dropping bus_req at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= next_state;
  end

  // Next-state decode plus handshake strobes; ack beats timeout in the last WAIT cycle.
  always_comb begin
    next_state = state;
    req_ready  = 1'b0;
    bus_req    = 1'b0;
    rsp_valid  = 1'b0;
    accept     = 1'b0;
    done_ack   = 1'b0;
    done_to    = 1'b0;
    case (state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          accept     = 1'b1;
          next_state = misal ? ST_DONE : ST_WAIT;
        end
      end
      ST_WAIT: begin
        bus_req = 1'b1;
        if (bus_ack) begin
          done_ack   = 1'b1;
          next_state = ST_DONE;
        end else if (cnt == CNT_LAST) begin
          done_to    = 1'b1;
          next_state = ST_DONE;
        end
      end
      ST_DONE: begin
        rsp_valid  = 1'b1;
        next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Cycles spent in WAIT; cleared whenever the unit is elsewhere.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                 cnt <= 8'd0;
    else if (state == ST_WAIT) cnt <= cnt + 8'd1;
    else                       cnt <= 8'd0;
  end

  // Capture the request so bus signals stay stable through WAIT.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      we_q     <= 1'b0;
      size_q   <= 2'b00;
      signed_q <= 1'b0;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
    end else if (accept) begin
      we_q     <= req_we;
      size_q   <= req_size;
      signed_q <= req_signed;
      addr_q   <= req_addr;
      wdata_q  <= req_wdata;
    end
  end

  // Response fields: cleared/flagged on accept, filled by ack or timeout.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata_q  <= 32'd0;
      adel_q   <= 1'b0;
      ades_q   <= 1'b0;
      buserr_q <= 1'b0;
    end else if (accept) begin
      rdata_q  <= 32'd0;
      adel_q   <= misal & ~req_we;
      ades_q   <= misal & req_we;
      buserr_q <= 1'b0;
    end else if (done_ack) begin
      rdata_q  <= we_q ? 32'd0 : lane_rdata;
    end else if (done_to) begin
      buserr_q <= 1'b1;
    end
  end

  // Bus fields are only driven while the access is live; be is zero on reads.
  assign bus_we    = bus_req & we_q;
  assign bus_addr  = bus_req ? {addr_q[31:2], 2'b00} : 32'd0;
  assign bus_be    = bus_we ? lane_be : 4'b0000;
  assign bus_wdata = bus_we ? lane_wdata : 32'd0;

  assign rsp_rdata  = rsp_valid ? rdata_q : 32'd0;
  assign rsp_adel   = rsp_valid & adel_q;
  assign rsp_ades   = rsp_valid & ades_q;
  assign rsp_buserr = rsp_valid & buserr_q;

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Multi-cycle load/store unit for the MIPS datapath. It sits between the MEM stage and the system bridge.
- Store path narrows data: it takes a 32-bit register value, replicates the byte or halfword into its lane, and emits a 4-bit byte enable.
- Load path widens data: it extracts the addressed byte or halfword from the bus word and zero- or sign-extends it to 32 bits.
- Owns the bus request/ack handshake, alignment-exception detection and the bus-timeout error.

Parameters:
- TIMEOUT, 16: maximum cycles spent in WAIT before a bus error is reported. Legal range 1..255.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  1  MEM stage presents an access.
- req_ready  output  1  unit can accept an access (high only in IDLE).
- req_we  input  1  1 = store, 0 = load.
- req_size  input  2  00 word, 01 half, 10 byte, 11 reserved (treated as word).
- req_signed  input  1  loads only: 1 = sign-extend, 0 = zero-extend.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data, taken from the low bits of the register.
- bus_req  output  1  bus access active.
- bus_we  output  1  bus write.
- bus_addr  output  32  word address; bits [1:0] are always 00.
- bus_be  output  4  byte enables; all 0 on reads.
- bus_wdata  output  32  lane-replicated store data.
- bus_ack  input  1  bus completes the access this cycle.
- bus_rdata  input  32  read word, valid when bus_ack is high.
- rsp_valid  output  1  one-cycle completion pulse.
- rsp_rdata  output  32  extended load result; 0 for stores and errors.
- rsp_adel  output  1  misaligned load.
- rsp_ades  output  1  misaligned store.
- rsp_buserr  output  1  bus timeout.

Behaviour:
- Reset values (asynchronous): state = IDLE. All outputs 0 except req_ready = 1. Timeout counter and all captured request fields = 0.
- States:
  - IDLE: req_ready = 1. On req_valid, capture we, size, signed, addr and wdata, then check alignment:
    - Misaligned means half with addr[0] = 1, or word/reserved with addr[1:0] != 00.
    - Misaligned: go to DONE with rsp_adel (load) or rsp_ades (store). No bus cycle is issued.
    - Aligned: go to WAIT.
  - WAIT: drive bus_req = 1 and hold bus_addr, bus_we, bus_be and bus_wdata stable for the whole state. The counter increments each cycle.
    - bus_ack = 1: latch the extended load data and go to DONE.
    - Counter reaches TIMEOUT-1 without ack: go to DONE with rsp_buserr = 1.
    - If ack arrives in the same cycle the counter reaches TIMEOUT-1, the ack wins and no error is reported.
  - DONE: rsp_valid = 1 for exactly one cycle with the registered response fields, then IDLE. req_ready = 0.
- Latency:
  - Aligned access with ack in its first WAIT cycle: accept at cycle N, bus_req high at N+1, rsp_valid at N+2.
  - Misaligned access: rsp_valid at N+1.
- Byte enables and write data:
  - Byte: be = 0001 shifted left by addr[1:0]; wdata = {4{wdata[7:0]}}.
  - Half: be = 0011 if addr[1] = 0, else 1100; wdata = {2{wdata[15:0]}}.
  - Word/reserved: be = 1111; wdata unchanged.
- Load extension:
  - Byte: select bus_rdata[8*addr[1:0] +: 8].
  - Half: select bus_rdata[16*addr[1] +: 16].
  - Word: pass through; req_signed is ignored.
  - Fill the upper bits with the selected MSB when req_signed = 1, else with zero.
- Only one access is in flight. req_valid is ignored outside IDLE, and bus_ack outside WAIT is ignored.
- Asynchronous reset mid-WAIT drops bus_req immediately and discards the access; no rsp_valid is produced.

Decomposition:
- Shared package mem_pkg holds:
  - size encodings SZ_WORD = 2'b00, SZ_HALF = 2'b01, SZ_BYTE = 2'b10;
  - state encoding ST_IDLE, ST_WAIT, ST_DONE.
- Natural sub-module: combinational lane_align (byte-enable/replication and select/extend logic), instantiated once.
- The FSM, counter and response registers stay in the top module.

Test Plan:
- Signed byte load: addr = 0x1003, bus_rdata = 0x80AA5511, ack on the first WAIT cycle -> bus_addr = 0x1000, bus_be = 0000; rsp_valid two cycles after accept; rsp_rdata = 0xFFFFFF80.
- Unsigned half load: addr = 0x2002, bus_rdata = 0x9ABC1234 -> rsp_rdata = 0x00009ABC. Repeat with req_signed = 1 -> 0xFFFF9ABC.
- Byte store: addr = 0x3001, wdata = 0x123456EF -> bus_we = 1, bus_be = 0010, bus_wdata = 0xEFEFEFEF; ack after 3 WAIT cycles -> rsp_valid with no error flags.
- Misaligned accesses:
  - Word load at 0x4002 -> no bus_req; rsp_adel = 1 one cycle after accept.
  - Half store at 0x4001 -> rsp_ades = 1.
- Timeout: with TIMEOUT = 16, never assert ack -> bus_req high for exactly 16 cycles, then rsp_buserr = 1 and rsp_rdata = 0.
  - Repeat with ack in the 16th WAIT cycle -> normal completion, rsp_buserr = 0.
- Reset mid-WAIT: assert reset in the 2nd WAIT cycle -> bus_req = 0 in the same cycle, req_ready = 1, no rsp_valid. The next access after reset completes normally.
